// File: rtl/retire_unit.sv
// +------------------------------------------------------------------+
// | retire_unit: two-wide commit, committed RAT, precise-exc restore  |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module retire_unit #(
  parameter int PREG_W    = 6,
  parameter int ROB_IDX_W = 5,
  parameter int ISSUE_W   = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ISSUE_W-1:0]                 commit_valid,
  input  logic [ISSUE_W-1:0][4:0]            commit_arch_rd,
  input  logic [ISSUE_W-1:0][PREG_W-1:0]     commit_phys_rd,
  input  logic [ISSUE_W-1:0]                 commit_exception,
  input  logic [ISSUE_W-1:0][ROB_IDX_W-1:0]  commit_rob_idx,
  input  logic [ISSUE_W-1:0]                 commit_is_store,
  input  logic [ISSUE_W-1:0]                 commit_is_branch,
  input  logic [ISSUE_W-1:0][31:0]           commit_pc,
  input  logic [ISSUE_W-1:0]                 commit_branch_taken,
  input  logic [ISSUE_W-1:0]                 commit_branch_is_call,
  input  logic [ISSUE_W-1:0]                 commit_branch_is_return,
  input  logic [ISSUE_W-1:0][31:0]           commit_branch_target,
  output logic [ISSUE_W-1:0]                 free_en,
  output logic [ISSUE_W-1:0][PREG_W-1:0]     free_preg,
  output logic [ISSUE_W-1:0]                 store_release_en,
  output logic [ISSUE_W-1:0][ROB_IDX_W-1:0]  store_release_idx,
  output logic [ISSUE_W-1:0]                 bp_upd_en,
  output logic [ISSUE_W-1:0][31:0]           bp_upd_pc,
  output logic [ISSUE_W-1:0][31:0]           bp_upd_target,
  output logic [ISSUE_W-1:0]                 bp_upd_taken,
  output logic [ISSUE_W-1:0]                 bp_upd_call,
  output logic [ISSUE_W-1:0]                 bp_upd_ret,
  output logic                               flush_req,
  output logic [ROB_IDX_W-1:0]               flush_rob_ptr,
  output logic [31:0]                        exc_pc,
  output logic                               restore_en,
  output logic [4:0]                         restore_arch,
  output logic [PREG_W-1:0]                  restore_preg,
  output logic                               busy,
  output logic [31:0]                        retired_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [31:0]            lat_pc_q, lat_pc_d;
  logic [ROB_IDX_W-1:0]   lat_rob_q, lat_rob_d;
  logic [PREG_W-1:0]      rat_q [32];

  logic                   idle;
  logic                   fault0, fault1;
  logic [ISSUE_W-1:0]     ret, dest;

  logic [ISSUE_W-1:0]                 free_en_d, st_en_d, bp_en_d;
  logic [ISSUE_W-1:0][PREG_W-1:0]     free_preg_d;
  logic [ISSUE_W-1:0][ROB_IDX_W-1:0]  st_idx_d;
  logic [ISSUE_W-1:0][31:0]           bp_pc_d, bp_tgt_d;
  logic [ISSUE_W-1:0]                 bp_tk_d, bp_call_d, bp_ret_d;

  assign idle   = (state_q == S_IDLE);
  assign fault0 = commit_valid[0] & commit_exception[0];
  assign fault1 = commit_valid[1] & commit_exception[1];

  // A faulting slot 0 blocks the younger slot 1 as well.
  assign ret[0] = idle & commit_valid[0] & ~commit_exception[0];
  assign ret[1] = idle & commit_valid[1] & ~commit_exception[1] & ~fault0;

  assign dest[0] = (commit_arch_rd[0] != 5'd31) & ~commit_is_store[0];
  assign dest[1] = (commit_arch_rd[1] != 5'd31) & ~commit_is_store[1];

  always_comb begin
    free_en_d   = '0;
    free_preg_d = '0;
    st_en_d     = '0;
    st_idx_d    = '0;
    bp_en_d     = '0;
    bp_pc_d     = '0;
    bp_tgt_d    = '0;
    bp_tk_d     = '0;
    bp_call_d   = '0;
    bp_ret_d    = '0;
    for (int j = 0; j < ISSUE_W; j++) begin
      if (ret[j] && dest[j]) begin
        free_en_d[j]   = 1'b1;
        free_preg_d[j] = rat_q[commit_arch_rd[j]];
      end
      if (ret[j] && commit_is_store[j]) begin
        st_en_d[j]  = 1'b1;
        st_idx_d[j] = commit_rob_idx[j];
      end
      if (ret[j] && commit_is_branch[j]) begin
        bp_en_d[j]   = 1'b1;
        bp_pc_d[j]   = commit_pc[j];
        bp_tgt_d[j]  = commit_branch_target[j];
        bp_tk_d[j]   = commit_branch_taken[j];
        bp_call_d[j] = commit_branch_is_call[j];
        bp_ret_d[j]  = commit_branch_is_return[j];
      end
    end
    // Slot 1 supersedes the mapping slot 0 created in the same cycle.
    if (free_en_d[0] && free_en_d[1] && (commit_arch_rd[0] == commit_arch_rd[1]))
      free_preg_d[1] = commit_phys_rd[0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_pc_d  = lat_pc_q;
    lat_rob_d = lat_rob_q;
    case (state_q)
      S_IDLE: begin
        if (fault0 || fault1) begin
          state_d   = S_FLUSH;
          lat_pc_d  = fault0 ? commit_pc[0] : commit_pc[1];
          lat_rob_d = fault0 ? commit_rob_idx[0] : commit_rob_idx[1];
        end
      end
      S_FLUSH: begin
        state_d = S_RESTORE;
        cnt_d   = 5'd0;
      end
      S_RESTORE: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      lat_pc_q  <= '0;
      lat_rob_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_pc_q  <= lat_pc_d;
      lat_rob_q <= lat_rob_d;
    end
  end

  // Slot 1 is written last so it wins on a same-register collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        rat_q[i] <= PREG_W'(i);
    end else begin
      if (free_en_d[0]) rat_q[commit_arch_rd[0]] <= commit_phys_rd[0];
      if (free_en_d[1]) rat_q[commit_arch_rd[1]] <= commit_phys_rd[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_en           <= '0;
      free_preg         <= '0;
      store_release_en  <= '0;
      store_release_idx <= '0;
      bp_upd_en         <= '0;
      bp_upd_pc         <= '0;
      bp_upd_target     <= '0;
      bp_upd_taken      <= '0;
      bp_upd_call       <= '0;
      bp_upd_ret        <= '0;
      flush_req         <= 1'b0;
      flush_rob_ptr     <= '0;
      exc_pc            <= '0;
      restore_en        <= 1'b0;
      restore_arch      <= '0;
      restore_preg      <= '0;
      busy              <= 1'b0;
      retired_count     <= '0;
    end else begin
      free_en           <= free_en_d;
      free_preg         <= free_preg_d;
      store_release_en  <= st_en_d;
      store_release_idx <= st_idx_d;
      bp_upd_en         <= bp_en_d;
      bp_upd_pc         <= bp_pc_d;
      bp_upd_target     <= bp_tgt_d;
      bp_upd_taken      <= bp_tk_d;
      bp_upd_call       <= bp_call_d;
      bp_upd_ret        <= bp_ret_d;
      flush_req         <= (state_q == S_FLUSH);
      flush_rob_ptr     <= (state_q == S_FLUSH) ? lat_rob_q : '0;
      exc_pc            <= (state_q == S_FLUSH) ? lat_pc_q : '0;
      restore_en        <= (state_q == S_RESTORE);
      restore_arch      <= (state_q == S_RESTORE) ? cnt_q : 5'd0;
      restore_preg      <= (state_q == S_RESTORE) ? rat_q[cnt_q] : '0;
      busy              <= (state_q != S_IDLE);
      retired_count     <= retired_count + 32'(ret[0]) + 32'(ret[1]);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_retire_unit.sv
// Randomised scoreboard bench for retire_unit against a sequential
// in-order retirement model.
`default_nettype none

module tb_retire_unit;
  localparam int PW = 6;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0]          commit_valid, commit_exception, commit_is_store, commit_is_branch;
  logic [1:0][4:0]     commit_arch_rd;
  logic [1:0][PW-1:0]  commit_phys_rd;
  logic [1:0][RW-1:0]  commit_rob_idx;
  logic [1:0][31:0]    commit_pc, commit_branch_target;
  logic [1:0]          commit_branch_taken, commit_branch_is_call, commit_branch_is_return;
  logic [1:0]          free_en, store_release_en, bp_upd_en;
  logic [1:0][PW-1:0]  free_preg;
  logic [1:0][RW-1:0]  store_release_idx;
  logic [1:0][31:0]    bp_upd_pc, bp_upd_target;
  logic [1:0]          bp_upd_taken, bp_upd_call, bp_upd_ret;
  logic                flush_req, restore_en, busy;
  logic [RW-1:0]       flush_rob_ptr;
  logic [31:0]         exc_pc, retired_count;
  logic [4:0]          restore_arch;
  logic [PW-1:0]       restore_preg;

  retire_unit #(.PREG_W(PW), .ROB_IDX_W(RW), .ISSUE_W(2)) dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_arch_rd(commit_arch_rd),
    .commit_phys_rd(commit_phys_rd), .commit_exception(commit_exception),
    .commit_rob_idx(commit_rob_idx), .commit_is_store(commit_is_store),
    .commit_is_branch(commit_is_branch), .commit_pc(commit_pc),
    .commit_branch_taken(commit_branch_taken), .commit_branch_is_call(commit_branch_is_call),
    .commit_branch_is_return(commit_branch_is_return), .commit_branch_target(commit_branch_target),
    .free_en(free_en), .free_preg(free_preg),
    .store_release_en(store_release_en), .store_release_idx(store_release_idx),
    .bp_upd_en(bp_upd_en), .bp_upd_pc(bp_upd_pc), .bp_upd_target(bp_upd_target),
    .bp_upd_taken(bp_upd_taken), .bp_upd_call(bp_upd_call), .bp_upd_ret(bp_upd_ret),
    .flush_req(flush_req), .flush_rob_ptr(flush_rob_ptr), .exc_pc(exc_pc),
    .restore_en(restore_en), .restore_arch(restore_arch), .restore_preg(restore_preg),
    .busy(busy), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          stamp;
    int          slot;
    logic [79:0] a;
    logic [79:0] b;
  } ev_t;

  ev_t fq[$], sq[$], bq[$], flq[$], rq[$], cq[$];
  bit  busy_at[int];
  logic [PW-1:0] mrat [32];
  logic [31:0]   mcnt;
  int            idle_from;
  bit            mon_on = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic ev_t mk(input int st, input int sl, input logic [79:0] a, input logic [79:0] b);
    ev_t e;
    e.stamp = st; e.slot = sl; e.a = a; e.b = b;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mrat[i] = PW'(i);
    mcnt = 32'd0;
    idle_from = 0;
    fq.delete(); sq.delete(); bq.delete(); flq.delete(); rq.delete(); cq.delete();
    busy_at.delete();
  endtask

  // Monitor: every output is compared against whatever the model scheduled for this cycle.
  always @(negedge clk) begin
    bit ex;
    if (mon_on && !reset) begin
      for (int j = 0; j < 2; j++) begin
        ex = (fq.size() > 0) && (fq[0].stamp == cyc) && (fq[0].slot == j);
        chk("free_en", 80'(free_en[j]), 80'(ex));
        if (ex) begin
          chk("free_preg", 80'(free_preg[j]), fq[0].a);
          void'(fq.pop_front());
        end else chk("free_preg_idle", 80'(free_preg[j]), '0);

        ex = (sq.size() > 0) && (sq[0].stamp == cyc) && (sq[0].slot == j);
        chk("store_release_en", 80'(store_release_en[j]), 80'(ex));
        if (ex) begin
          chk("store_release_idx", 80'(store_release_idx[j]), sq[0].a);
          void'(sq.pop_front());
        end else chk("store_idx_idle", 80'(store_release_idx[j]), '0);

        ex = (bq.size() > 0) && (bq[0].stamp == cyc) && (bq[0].slot == j);
        chk("bp_upd_en", 80'(bp_upd_en[j]), 80'(ex));
        if (ex) begin
          chk("bp_upd_payload", 80'({bp_upd_pc[j], bp_upd_target[j], bp_upd_taken[j],
                                     bp_upd_call[j], bp_upd_ret[j]}), bq[0].a);
          void'(bq.pop_front());
        end else chk("bp_payload_idle", 80'({bp_upd_pc[j], bp_upd_target[j], bp_upd_taken[j],
                                              bp_upd_call[j], bp_upd_ret[j]}), '0);
      end

      ex = (flq.size() > 0) && (flq[0].stamp == cyc);
      chk("flush_req", 80'(flush_req), 80'(ex));
      if (ex) begin
        chk("exc_pc", 80'(exc_pc), flq[0].a);
        chk("flush_rob_ptr", 80'(flush_rob_ptr), flq[0].b);
        void'(flq.pop_front());
      end

      ex = (rq.size() > 0) && (rq[0].stamp == cyc);
      chk("restore_en", 80'(restore_en), 80'(ex));
      if (ex) begin
        chk("restore_arch", 80'(restore_arch), rq[0].a);
        chk("restore_preg", 80'(restore_preg), rq[0].b);
        void'(rq.pop_front());
      end

      chk("busy", 80'(busy), 80'(busy_at.exists(cyc)));

      if ((cq.size() > 0) && (cq[0].stamp == cyc)) begin
        chk("retired_count", 80'(retired_count), cq[0].a);
        void'(cq.pop_front());
      end
    end
  end

  // Apply the current inputs for one cycle and record what the model expects.
  task automatic step();
    int c;
    int fault;
    c = cyc;
    if (c >= idle_from) begin
      fault = -1;
      for (int j = 0; j < 2; j++) begin
        if (commit_valid[j]) begin
          if (commit_exception[j]) begin
            fault = j;
            break;
          end
          if (commit_arch_rd[j] != 5'd31 && !commit_is_store[j]) begin
            fq.push_back(mk(c + 1, j, 80'(mrat[commit_arch_rd[j]]), '0));
            mrat[commit_arch_rd[j]] = commit_phys_rd[j];
          end
          if (commit_is_store[j])
            sq.push_back(mk(c + 1, j, 80'(commit_rob_idx[j]), '0));
          if (commit_is_branch[j])
            bq.push_back(mk(c + 1, j, 80'({commit_pc[j], commit_branch_target[j],
                                           commit_branch_taken[j], commit_branch_is_call[j],
                                           commit_branch_is_return[j]}), '0));
          mcnt = mcnt + 32'd1;
        end
      end
      if (fault >= 0) begin
        flq.push_back(mk(c + 2, 0, 80'(commit_pc[fault]), 80'(commit_rob_idx[fault])));
        for (int k = 0; k < 32; k++)
          rq.push_back(mk(c + 3 + k, 0, 80'(k), 80'(mrat[k])));
        for (int k = 2; k <= 34; k++) busy_at[c + k] = 1'b1;
        idle_from = c + 34;
      end
    end
    cq.push_back(mk(c + 1, 0, 80'(mcnt), '0));
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    commit_valid = '0; commit_exception = '0; commit_is_store = '0; commit_is_branch = '0;
    commit_arch_rd = '0; commit_phys_rd = '0; commit_rob_idx = '0; commit_pc = '0;
    commit_branch_target = '0; commit_branch_taken = '0; commit_branch_is_call = '0;
    commit_branch_is_return = '0;
  endtask

  task automatic set_slot(input int j, input bit e, input logic [4:0] rd, input logic [PW-1:0] ph,
                          input bit st, input bit br, input logic [31:0] pc, input logic [RW-1:0] rob);
    commit_valid[j] = 1'b1; commit_exception[j] = e; commit_arch_rd[j] = rd;
    commit_phys_rd[j] = ph; commit_is_store[j] = st; commit_is_branch[j] = br;
    commit_pc[j] = pc; commit_rob_idx[j] = rob;
    commit_branch_target[j] = $urandom; commit_branch_taken[j] = 1'($urandom);
    commit_branch_is_call[j] = 1'($urandom); commit_branch_is_return[j] = 1'($urandom);
  endtask

  task automatic rand_in();
    for (int j = 0; j < 2; j++) begin
      commit_valid[j] = ($urandom_range(0, 3) != 0);
      commit_exception[j] = ($urandom_range(0, 30) == 0);
      commit_arch_rd[j] = 5'($urandom_range(0, 31));
      commit_phys_rd[j] = PW'($urandom);
      commit_is_store[j] = ($urandom_range(0, 3) == 0);
      commit_is_branch[j] = ($urandom_range(0, 3) == 0);
      commit_rob_idx[j] = RW'($urandom);
      commit_pc[j] = $urandom;
      commit_branch_target[j] = $urandom;
      commit_branch_taken[j] = 1'($urandom);
      commit_branch_is_call[j] = 1'($urandom);
      commit_branch_is_return[j] = 1'($urandom);
    end
    // Keep rd collisions frequent.
    if ($urandom_range(0, 3) == 0) commit_arch_rd[1] = commit_arch_rd[0];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_free_en"}, 80'(free_en), '0);
    chk({tag, "_store_en"}, 80'(store_release_en), '0);
    chk({tag, "_bp_en"}, 80'(bp_upd_en), '0);
    chk({tag, "_flush_req"}, 80'(flush_req), '0);
    chk({tag, "_restore_en"}, 80'(restore_en), '0);
    chk({tag, "_restore_preg"}, 80'(restore_preg), '0);
    chk({tag, "_busy"}, 80'(busy), '0);
    chk({tag, "_retired_count"}, 80'(retired_count), '0);
  endtask

  initial begin
    clr_in();
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    mon_on = 1'b1;

    // Two independent destinations.
    clr_in(); set_slot(0, 0, 5'd3, 6'd40, 0, 0, 32'h10, 5'd1);
    set_slot(1, 0, 5'd5, 6'd41, 0, 1, 32'h14, 5'd2);
    step(); clr_in(); step();

    // Same-cycle write to x7.
    set_slot(0, 0, 5'd7, 6'd50, 0, 0, 32'h18, 5'd3);
    set_slot(1, 0, 5'd7, 6'd51, 0, 0, 32'h1c, 5'd4);
    step(); clr_in(); step();

    // XZR write and a store.
    set_slot(0, 0, 5'd31, 6'd20, 0, 0, 32'h20, 5'd5);
    set_slot(1, 0, 5'd9, 6'd22, 1, 0, 32'h24, 5'd12);
    step(); clr_in(); step();

    // Older slot retires, younger slot faults; junk commits during recovery.
    set_slot(0, 0, 5'd2, 6'd33, 0, 0, 32'h0fc, 5'd8);
    set_slot(1, 1, 5'd4, 6'd34, 0, 0, 32'h100, 5'd9);
    step();
    repeat (34) begin
      rand_in(); commit_exception = '0; step();
    end
    clr_in(); repeat (3) step();

    // Fault then asynchronous reset in the middle of the restore stream.
    set_slot(0, 1, 5'd6, 6'd60, 0, 0, 32'h200, 5'd3);
    step(); clr_in();
    repeat (12) step();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fresh retire on the identity RAT, then a restore to expose the table.
    set_slot(0, 0, 5'd3, 6'd40, 0, 0, 32'h300, 5'd1);
    set_slot(1, 0, 5'd5, 6'd41, 0, 0, 32'h304, 5'd2);
    step(); clr_in(); step();
    set_slot(1, 1, 5'd0, 6'd0, 0, 0, 32'h308, 5'd7);
    step(); clr_in();
    repeat (36) step();

    repeat (1500) begin
      rand_in(); step();
    end
    clr_in();
    repeat (40) step();

    chk("free_queue_drained", 80'(fq.size()), '0);
    chk("store_queue_drained", 80'(sq.size()), '0);
    chk("bp_queue_drained", 80'(bq.size()), '0);
    chk("flush_queue_drained", 80'(flq.size()), '0);
    chk("restore_queue_drained", 80'(rq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
